// File: rtl/golden_nonce_collector_if.sv
// Bus between the host/comparator side and golden_nonce_collector.
// The host and comparator side uses the master modport and the collector uses the slave modport.
interface golden_nonce_collector_if;
    logic         start;
    logic         stop;
    logic         cmp_nonce_re;
    logic         cmp_result;
    logic [255:0] cmp_hash;
    logic [63:0]  nonce_din;
    logic         nonce_din_we;
    logic         rd_re;
    logic [31:0]  rd_dout;
    logic         rd_valid;
    logic         full;
    logic [31:0]  golden_cnt;
    logic [15:0]  drop_cnt;
    logic         err;

    modport master (
        output start, stop, cmp_nonce_re, cmp_result, cmp_hash, nonce_din, nonce_din_we, rd_re,
        input  rd_dout, rd_valid, full, golden_cnt, drop_cnt, err
    );

    modport slave (
        input  start, stop, cmp_nonce_re, cmp_result, cmp_hash, nonce_din, nonce_din_we, rd_re,
        output rd_dout, rd_valid, full, golden_cnt, drop_cnt, err
    );
endinterface

// File: rtl/golden_nonce_collector.sv
// Pairs comparator results with nonces and buffers golden entries for host readout as 32-bit words.
// Define GOLDEN_HASH_CAPTURE_EN to also store the 256-bit hash with each entry (10 words per entry instead of 2).
module golden_nonce_collector #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    golden_nonce_collector_if.slave   bus
);
`ifdef GOLDEN_HASH_CAPTURE_EN
    localparam int WORDS = 10;
`else
    localparam int WORDS = 2;
`endif
    localparam int AW      = $clog2(DEPTH);
    localparam int PW      = AW + 1;
    localparam int WPW     = $clog2(WORDS);
    localparam int TW      = $clog2(TIMEOUT + 1);
    localparam int ENTRY_W = WORDS * 32;

    typedef enum logic [1:0] {IDLE, WAIT_NONCE, PUSH} state_t;

    state_t              state;
    logic [TW-1:0]       tcnt;
    logic [PW-1:0]       wr_ptr, rd_ptr, wr_ptr_n, rd_ptr_n;
    logic [WPW-1:0]      wptr, wptr_n;
    logic [31:0]         rd_dout_r, rd_dout_n, golden_cnt_r;
    logic [15:0]         drop_cnt_r;
    logic                err_r;
    logic                gold_q;
    logic [63:0]         nonce_q;
    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [ENTRY_W-1:0]  entry_wdata, head;
    logic                empty, full_w, push_en, pop_word, pop_entry, gold_now, bypass;
    logic [1:0]          rst_sync;
    logic                rst_int_n;

    // Assert asynchronously, release two clocks after rst_n rises
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_int_n = rst_sync[1];

`ifdef GOLDEN_HASH_CAPTURE_EN
    logic [255:0] hash_q;
    always_ff @(posedge clk) begin
        if (state == WAIT_NONCE && tcnt == '0) hash_q <= bus.cmp_hash;
    end
    assign entry_wdata = {hash_q, nonce_q};
`else
    logic unused_hash;
    assign unused_hash = ^bus.cmp_hash;
    assign entry_wdata = nonce_q;
`endif

    assign empty     = (wr_ptr == rd_ptr);
    assign full_w    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign push_en   = (state == PUSH) && !bus.stop && !full_w;
    assign pop_word  = bus.rd_re && !empty;
    assign pop_entry = pop_word && (wptr == WPW'(WORDS - 1));
    assign gold_now  = (tcnt == '0) ? bus.cmp_result : gold_q;

    assign wr_ptr_n = bus.start ? '0 : wr_ptr + PW'(push_en);
    assign rd_ptr_n = bus.start ? '0 : rd_ptr + PW'(pop_entry);
    assign wptr_n   = bus.start ? '0 : (pop_entry ? '0 : (pop_word ? wptr + WPW'(1) : wptr));

    // The head after this edge may be the entry being written now, so forward it
    assign bypass = push_en && !bus.start && (rd_ptr_n == wr_ptr);

    always_comb begin
        head      = bypass ? entry_wdata : mem[rd_ptr_n[AW-1:0]];
        rd_dout_n = '0;
        if (wr_ptr_n != rd_ptr_n) rd_dout_n = head[int'(wptr_n)*32 +: 32];
    end

    always_ff @(posedge clk) begin
        if (state == WAIT_NONCE && tcnt == '0) gold_q <= bus.cmp_result;
        if (state == WAIT_NONCE && bus.nonce_din_we) nonce_q <= bus.nonce_din;
        if (push_en && !bus.start) mem[wr_ptr[AW-1:0]] <= entry_wdata;
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state        <= IDLE;
            tcnt         <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            wptr         <= '0;
            rd_dout_r    <= '0;
            golden_cnt_r <= '0;
            drop_cnt_r   <= '0;
            err_r        <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_n;
            rd_ptr    <= rd_ptr_n;
            wptr      <= wptr_n;
            rd_dout_r <= rd_dout_n;
            if (bus.start) begin
                state        <= IDLE;
                tcnt         <= '0;
                golden_cnt_r <= '0;
                drop_cnt_r   <= '0;
                err_r        <= 1'b0;
            end else if (bus.stop) begin
                state <= IDLE;
                tcnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        tcnt <= '0;
                        if (bus.cmp_nonce_re) state <= WAIT_NONCE;
                    end
                    WAIT_NONCE: begin
                        if (bus.nonce_din_we) begin
                            state <= gold_now ? PUSH : IDLE;
                        end else if (tcnt == TW'(TIMEOUT - 1)) begin
                            err_r <= 1'b1;
                            state <= IDLE;
                        end else begin
                            tcnt <= tcnt + TW'(1);
                        end
                    end
                    PUSH: begin
                        golden_cnt_r <= golden_cnt_r + 32'd1;
                        if (full_w && drop_cnt_r != 16'hFFFF) drop_cnt_r <= drop_cnt_r + 16'd1;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.rd_dout    = rd_dout_r;
    assign bus.rd_valid   = !empty;
    assign bus.full       = full_w;
    assign bus.golden_cnt = golden_cnt_r;
    assign bus.drop_cnt   = drop_cnt_r;
    assign bus.err        = err_r;
endmodule

// File: tb/tb_golden_nonce_collector.sv
// Directed bench for golden_nonce_collector; expected readout words are queued at capture time.
module tb_golden_nonce_collector;
`ifdef GOLDEN_HASH_CAPTURE_EN
    localparam int WORDS = 10;
`else
    localparam int WORDS = 2;
`endif
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    golden_nonce_collector_if bus ();
    golden_nonce_collector #(.DEPTH(DEPTH), .TIMEOUT(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] exp_q [$];
    int          m_entries = 0;
    int          m_word    = 0;
    logic [31:0] m_golden  = 0;
    logic [15:0] m_drop    = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        exp_q.delete();
        m_entries = 0;
        m_word    = 0;
        m_golden  = 0;
        m_drop    = 0;
    endtask

    task automatic model_push(input logic [63:0] nonce, input logic [255:0] hash);
        m_golden++;
        if (m_entries >= DEPTH) begin
            if (m_drop != 16'hFFFF) m_drop++;
        end else begin
            m_entries++;
            exp_q.push_back(nonce[31:0]);
            exp_q.push_back(nonce[63:32]);
            for (int i = 0; i < WORDS - 2; i++) exp_q.push_back(hash[i*32 +: 32]);
        end
    endtask

    // One full comparator transaction: re pulse, result + nonce next cycle, one more edge for PUSH
    task automatic capture(input logic res, input logic [63:0] nonce, input logic [255:0] hash);
        bus.cmp_nonce_re = 1'b1;
        bus.cmp_hash     = hash;
        tick();
        bus.cmp_nonce_re = 1'b0;
        bus.cmp_result   = res;
        bus.nonce_din    = nonce;
        bus.nonce_din_we = 1'b1;
        tick();
        bus.nonce_din_we = 1'b0;
        bus.cmp_result   = 1'b0;
        tick();
        if (res) model_push(nonce, hash);
    endtask

    task automatic read_word(input string tag);
        logic [31:0] e;
        e = 32'hxxxx_xxxx;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        chk({tag, "_valid"}, bus.rd_valid, 1'b1);
        chk({tag, "_dout"}, bus.rd_dout, e);
        bus.rd_re = 1'b1;
        tick();
        bus.rd_re = 1'b0;
        m_word++;
        if (m_word == WORDS) begin
            m_word = 0;
            m_entries--;
        end
    endtask

    task automatic drain(input string tag);
        while (m_entries > 0) read_word(tag);
        chk({tag, "_empty_valid"}, bus.rd_valid, 1'b0);
        chk({tag, "_empty_dout"}, bus.rd_dout, 32'h0);
    endtask

    task automatic check_stats(input string tag);
        chk({tag, "_golden"}, bus.golden_cnt, m_golden);
        chk({tag, "_drop"}, bus.drop_cnt, m_drop);
        chk({tag, "_full"}, bus.full, (m_entries == DEPTH));
    endtask

    initial begin
        bus.start = 0; bus.stop = 0; bus.cmp_nonce_re = 0; bus.cmp_result = 0;
        bus.cmp_hash = '0; bus.nonce_din = '0; bus.nonce_din_we = 0; bus.rd_re = 0;
        tick(); tick();
        chk("rst_valid", bus.rd_valid, 1'b0);
        chk("rst_dout", bus.rd_dout, 32'h0);
        chk("rst_full", bus.full, 1'b0);
        chk("rst_golden", bus.golden_cnt, 32'h0);
        chk("rst_drop", bus.drop_cnt, 16'h0);
        chk("rst_err", bus.err, 1'b0);
        rst_n = 1'b1;
        tick(); tick(); tick();
        do_start();

        // single golden capture, hash low bytes 0102
        capture(1'b1, 64'h0000_0001_DEAD_BEEF, {32'h1111_2222, 192'h0, 32'h0000_0102});
        chk("gold1_valid", bus.rd_valid, 1'b1);
        check_stats("gold1");
        drain("gold1");

        // read strobe on empty buffer is ignored
        bus.rd_re = 1'b1;
        tick();
        bus.rd_re = 1'b0;
        chk("rd_empty_valid", bus.rd_valid, 1'b0);
        chk("rd_empty_dout", bus.rd_dout, 32'h0);

        do_start();
        capture(1'b0, 64'h5, 256'h0);
        chk("nongold_valid", bus.rd_valid, 1'b0);
        check_stats("nongold");

        // overflow: 5 golden into a 4-deep buffer
        for (int i = 1; i <= 5; i++) capture(1'b1, 64'(i), {8{32'(i + 100)}});
        check_stats("ovf");
        drain("ovf");
        check_stats("ovf_after");

        // timeout: 8 WAIT cycles without nonce_din_we
        bus.cmp_nonce_re = 1'b1;
        tick();
        bus.cmp_nonce_re = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("tmo_err_early", bus.err, 1'b0);
        tick();
        chk("tmo_err", bus.err, 1'b1);
        capture(1'b1, 64'hCAFE_F00D_1234_5678, {8{32'hA5A5_0001}});
        check_stats("tmo_next");
        drain("tmo_next");

        // stop during WAIT_NONCE discards the pending golden nonce
        bus.cmp_nonce_re = 1'b1;
        tick();
        bus.cmp_nonce_re = 1'b0;
        bus.stop = 1'b1;
        bus.cmp_result = 1'b1;
        tick();
        bus.nonce_din = 64'h77;
        bus.nonce_din_we = 1'b1;
        tick();
        bus.nonce_din_we = 1'b0;
        bus.cmp_result = 1'b0;
        tick();
        bus.stop = 1'b0;
        tick();
        chk("stop_valid", bus.rd_valid, 1'b0);
        check_stats("stop");
        chk("stop_err_kept", bus.err, 1'b1);
        do_start();
        chk("start_err", bus.err, 1'b0);
        check_stats("start");
        chk("start_valid", bus.rd_valid, 1'b0);

        // push into a full buffer drops even when the final word is popped on the same edge
        for (int i = 1; i <= 4; i++) capture(1'b1, {32'(i), 32'(i + 16)}, {8{32'(i)}});
        for (int i = 0; i < WORDS - 1; i++) read_word("pp_pre");
        bus.cmp_nonce_re = 1'b1;
        tick();
        bus.cmp_nonce_re = 1'b0;
        bus.cmp_result = 1'b1;
        bus.nonce_din = 64'h99;
        bus.nonce_din_we = 1'b1;
        tick();
        bus.nonce_din_we = 1'b0;
        bus.cmp_result = 1'b0;
        model_push(64'h99, 256'h0);
        read_word("pp_last");
        check_stats("pp");
        drain("pp");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench timeout");
    end
endmodule
